// File: rtl/eco32f_fetch.sv
// eco32f instruction-fetch stage.
// Owns the fetch PC and a req/ack instruction-bus master, and feeds decode
// with an instruction, its PC and any fetch-exception flags. Redirects from
// later stages override everything else.
// Optional one-entry skid buffer: define ECO32F_FETCH_BUF_EN. Without it,
// the bus request is masked while decode stalls.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | first cycle after reset release, no request yet
// S_REQ  | fetching from fetch_pc
// S_HOLD | acked instruction parked in the skid buffer (buffer builds only)
// S_HALT | a fault went to decode; wait for a redirect
module eco32f_fetch #(
    parameter logic [31:0] RESET_PC = 32'hE0000000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] ibus_adr_o,
    output logic        ibus_req_o,
    input  logic        ibus_ack_i,
    input  logic        ibus_err_i,
    input  logic [31:0] ibus_dat_i,
    input  logic        itlb_kmiss_i,
    input  logic        itlb_umiss_i,
    input  logic        itlb_invalid_i,
    input  logic        itlb_priv_i,
    input  logic        if_redirect,
    input  logic [31:0] if_redirect_pc,
    input  logic        id_stall,
    output logic [31:0] id_pc,
    output logic [31:0] id_insn,
    output logic        id_exc_ibus_fault,
    output logic        id_exc_itlb_kmiss,
    output logic        id_exc_itlb_umiss,
    output logic        id_exc_itlb_invalid,
    output logic        id_exc_itlb_priv
);

    localparam logic [31:0] NOP = 32'h00000000;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_HALT} state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic        itlb_any;
    logic        unused_ok;

`ifdef ECO32F_FETCH_BUF_EN
    logic [31:0] buf_insn;
    logic [31:0] buf_pc;
    logic        buf_err;
`endif

    // Redirect targets are word aligned; the low bits are dropped on load.
    assign unused_ok  = ^if_redirect_pc[1:0];
    assign itlb_any   = itlb_kmiss_i | itlb_umiss_i | itlb_invalid_i | itlb_priv_i;
    assign ibus_adr_o = fetch_pc;

    // Request only while fetching with a clean translation and no redirect.
`ifdef ECO32F_FETCH_BUF_EN
    assign ibus_req_o = (state == S_REQ) & ~itlb_any & ~if_redirect;
`else
    assign ibus_req_o = (state == S_REQ) & ~itlb_any & ~if_redirect & ~id_stall;
`endif

    // Fetch FSM, fetch PC and the registered decode-stage outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state               <= S_IDLE;
            fetch_pc            <= {RESET_PC[31:2], 2'b00};
            id_pc               <= RESET_PC;
            id_insn             <= NOP;
            id_exc_ibus_fault   <= 1'b0;
            id_exc_itlb_kmiss   <= 1'b0;
            id_exc_itlb_umiss   <= 1'b0;
            id_exc_itlb_invalid <= 1'b0;
            id_exc_itlb_priv    <= 1'b0;
`ifdef ECO32F_FETCH_BUF_EN
            buf_insn            <= NOP;
            buf_pc              <= RESET_PC;
            buf_err             <= 1'b0;
`endif
        end else if (if_redirect) begin
            // Discards any buffered entry simply by leaving S_HOLD.
            state               <= S_REQ;
            fetch_pc            <= {if_redirect_pc[31:2], 2'b00};
            id_insn             <= NOP;
            id_exc_ibus_fault   <= 1'b0;
            id_exc_itlb_kmiss   <= 1'b0;
            id_exc_itlb_umiss   <= 1'b0;
            id_exc_itlb_invalid <= 1'b0;
            id_exc_itlb_priv    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: state <= S_REQ;
                S_REQ: begin
                    if (!id_stall) begin
                        id_pc               <= fetch_pc;
                        id_insn             <= NOP;
                        id_exc_ibus_fault   <= 1'b0;
                        id_exc_itlb_kmiss   <= 1'b0;
                        id_exc_itlb_umiss   <= 1'b0;
                        id_exc_itlb_invalid <= 1'b0;
                        id_exc_itlb_priv    <= 1'b0;
                        if (itlb_any) begin
                            id_exc_itlb_kmiss   <= itlb_kmiss_i;
                            id_exc_itlb_umiss   <= itlb_umiss_i & ~itlb_kmiss_i;
                            id_exc_itlb_invalid <= itlb_invalid_i & ~itlb_kmiss_i & ~itlb_umiss_i;
                            id_exc_itlb_priv    <= itlb_priv_i & ~itlb_kmiss_i & ~itlb_umiss_i
                                                   & ~itlb_invalid_i;
                            state               <= S_HALT;
                        end else if (ibus_req_o && ibus_err_i) begin
                            id_exc_ibus_fault <= 1'b1;
                            state             <= S_HALT;
                        end else if (ibus_req_o && ibus_ack_i) begin
                            id_insn  <= ibus_dat_i;
                            fetch_pc <= fetch_pc + 32'd4;
                        end
                    end
`ifdef ECO32F_FETCH_BUF_EN
                    else if (ibus_req_o && (ibus_ack_i || ibus_err_i)) begin
                        // Decode is busy: park the response so the bus cycle completes.
                        buf_insn <= ibus_dat_i;
                        buf_pc   <= fetch_pc;
                        buf_err  <= ibus_err_i;
                        if (!ibus_err_i)
                            fetch_pc <= fetch_pc + 32'd4;
                        state    <= S_HOLD;
                    end
`endif
                end
                S_HOLD: begin
`ifdef ECO32F_FETCH_BUF_EN
                    if (!id_stall) begin
                        id_pc               <= buf_pc;
                        id_insn             <= buf_err ? NOP : buf_insn;
                        id_exc_ibus_fault   <= buf_err;
                        id_exc_itlb_kmiss   <= 1'b0;
                        id_exc_itlb_umiss   <= 1'b0;
                        id_exc_itlb_invalid <= 1'b0;
                        id_exc_itlb_priv    <= 1'b0;
                        state               <= buf_err ? S_HALT : S_REQ;
                    end
`else
                    state <= S_REQ;
`endif
                end
                S_HALT: begin
                    // Once decode has taken the fault, present bubbles.
                    if (!id_stall) begin
                        id_insn             <= NOP;
                        id_exc_ibus_fault   <= 1'b0;
                        id_exc_itlb_kmiss   <= 1'b0;
                        id_exc_itlb_umiss   <= 1'b0;
                        id_exc_itlb_invalid <= 1'b0;
                        id_exc_itlb_priv    <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
